// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor: sweeps all 4x4 operand pairs through an external multiplier and accumulates error stats.
// Define MRED_EN to add the serial divider that accumulates summed relative error.
module approx_mult_error_monitor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  op_a,
    output logic [3:0]  op_b,
    input  logic [7:0]  approx_result,
    output logic [15:0] sum_abs_err,
    output logic [8:0]  err_count,
    output logic [7:0]  max_err,
    output logic [3:0]  max_err_a,
    output logic [3:0]  max_err_b,
    output logic [25:0] sum_rel_err
);
`ifdef MRED_EN
    typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, DIVIDE, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
`endif
    state_t      state_q;
    logic [7:0]  idx_q;
    logic        busy_q, done_q;
    logic [15:0] sum_abs_q;
    logic [8:0]  err_cnt_q;
    logic [7:0]  max_err_q;
    logic [3:0]  max_a_q, max_b_q;
    logic [7:0]  exact, err;
    logic        adv;
`ifdef MRED_EN
    logic [25:0] sum_rel_q;
    logic [7:0]  rem_q, rem_d;
    logic [17:0] quo_q, quo_d;
    logic [4:0]  cnt_q;
    logic [8:0]  trial;
    logic        ge;
`endif
    always_comb begin
        exact = {4'b0, idx_q[7:4]} * {4'b0, idx_q[3:0]};
        err   = approx_result >= exact ? approx_result - exact : exact - approx_result;
`ifdef MRED_EN
        // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
        trial = {rem_q, quo_q[17]};
        ge    = trial >= {1'b0, exact};
        rem_d = ge ? trial[7:0] - exact : trial[7:0];
        quo_d = {quo_q[16:0], ge};
        adv   = (state_q == SAMPLE && exact == 8'd0) || (state_q == DIVIDE && cnt_q == 5'd17);
`else
        adv   = state_q == SAMPLE;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_abs_q <= '0;
            err_cnt_q <= '0;
            max_err_q <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
`ifdef MRED_EN
            sum_rel_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= APPLY;
                    idx_q     <= '0;
                    busy_q    <= 1'b1;
                    sum_abs_q <= '0;
                    err_cnt_q <= '0;
                    max_err_q <= '0;
                    max_a_q   <= '0;
                    max_b_q   <= '0;
`ifdef MRED_EN
                    sum_rel_q <= '0;
`endif
                end
                APPLY: state_q <= SAMPLE;
                SAMPLE: begin
                    sum_abs_q <= sum_abs_q + {8'b0, err};
                    err_cnt_q <= err_cnt_q + 9'(err != 8'd0);
                    if (err > max_err_q) begin
                        max_err_q <= err;
                        max_a_q   <= idx_q[7:4];
                        max_b_q   <= idx_q[3:0];
                    end
`ifdef MRED_EN
                    if (exact != 8'd0) begin
                        state_q <= DIVIDE;
                        rem_q   <= '0;
                        quo_q   <= {err, 10'b0};
                        cnt_q   <= '0;
                    end
`endif
                end
`ifdef MRED_EN
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd17)
                        sum_rel_q <= sum_rel_q + {8'b0, quo_d};
                end
`endif
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (adv) begin
                if (idx_q == 8'hff) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= APPLY;
                    idx_q   <= idx_q + 8'd1;
                end
            end
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign op_a        = idx_q[7:4];
    assign op_b        = idx_q[3:0];
    assign sum_abs_err = sum_abs_q;
    assign err_count   = err_cnt_q;
    assign max_err     = max_err_q;
    assign max_err_a   = max_a_q;
    assign max_err_b   = max_b_q;
`ifdef MRED_EN
    assign sum_rel_err = sum_rel_q;
`else
    assign sum_rel_err = '0;
`endif
endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// tb_approx_mult_error_monitor: drives table-based multiplier models and checks the monitor against a plain arithmetic reference.
module tb_approx_mult_error_monitor;
    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [3:0]  op_a, op_b, max_err_a, max_err_b;
    logic [7:0]  approx_result, max_err;
    logic [15:0] sum_abs_err;
    logic [8:0]  err_count;
    logic [25:0] sum_rel_err;
    logic [7:0]  lut [256];
    int n_chk = 0, n_err = 0;
    int e_sum, e_cnt, e_max, e_ma, e_mb, e_rel, e_cyc;

    always #5 clk = ~clk;
    assign approx_result = lut[{op_a, op_b}];

    approx_mult_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .op_a(op_a), .op_b(op_b), .approx_result(approx_result),
        .sum_abs_err(sum_abs_err), .err_count(err_count), .max_err(max_err),
        .max_err_a(max_err_a), .max_err_b(max_err_b), .sum_rel_err(sum_rel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_exact();
        for (int i = 0; i < 256; i++) lut[i] = 8'((i / 16) * (i % 16));
    endtask

    task automatic model();
        e_sum = 0; e_cnt = 0; e_max = 0; e_ma = 0; e_mb = 0; e_rel = 0; e_cyc = 1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                int x, y, d;
                x = a * b;
                y = int'(lut[a * 16 + b]);
                d = y > x ? y - x : x - y;
                e_sum += d;
                if (d != 0) e_cnt++;
                if (d > e_max) begin e_max = d; e_ma = a; e_mb = b; end
`ifdef MRED_EN
                if (x != 0) begin e_rel += d * 1024 / x; e_cyc += 20; end
                else e_cyc += 2;
`else
                e_cyc += 2;
`endif
            end
    endtask

    task automatic sweep(input string tag, input int kick);
        int cyc, lo;
        model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        lo = 0;
        while (!done && cyc < 6000) begin
            if (!busy) lo++;
            start = (cyc == kick);
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".done_cycle"}, cyc, e_cyc);
        chk({tag, ".busy_gaps"}, lo, 0);
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".sum_abs"}, sum_abs_err, e_sum);
        chk({tag, ".err_count"}, err_count, e_cnt);
        chk({tag, ".max_err"}, max_err, e_max);
        chk({tag, ".max_a"}, max_err_a, e_ma);
        chk({tag, ".max_b"}, max_err_b, e_mb);
        chk({tag, ".sum_rel"}, sum_rel_err, e_rel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".done_pulse"}, done, 0);
        @(negedge clk);
        chk({tag, ".idle_busy"}, busy, 0);
        chk({tag, ".hold_sum"}, sum_abs_err, e_sum);
    endtask

    task automatic rand_lut();
        set_exact();
        for (int i = 0; i < 256; i++)
            if ($urandom_range(3) == 0) lut[i] = 8'($urandom_range(255));
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        start = 1'b0;
        set_exact();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.ops", {op_a, op_b}, 0);
        chk("reset.stats", {sum_abs_err, err_count, max_err} | {max_err_a, max_err_b} | sum_rel_err, 0);

        sweep("exact", -1);

        for (int i = 0; i < 256; i++) lut[i] = 8'((i / 16) * (i % 16) == 255 ? 255 : (i / 16) * (i % 16) + 1);
        sweep("plus_one", 37);

        set_exact();
        lut[255] = 8'd0;
        sweep("max_corner", -1);

        set_exact();
        lut[17] = 8'd2;
        sweep("one_one", 300);

        for (int t = 0; t < 3; t++) begin
            rand_lut();
            sweep($sformatf("rand%0d", t), int'($urandom_range(400, 1)));
        end

        rand_lut();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.ops", {op_a, op_b}, 0);
        chk("midrst.sum_abs", sum_abs_err, 0);
        chk("midrst.err_count", err_count, 0);
        chk("midrst.max", {max_err, max_err_a, max_err_b}, 0);
        chk("midrst.sum_rel", sum_rel_err, 0);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst.no_done", nd, 0);
        sweep("after_rst", -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
